// File: rtl/vga_pkg.sv
// Shared types and nominal 640x480 timing constants for the VGA sync decoder.
`timescale 1ns/1ps
package vga_pkg;

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} sync_state_t;

    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int H_TOTAL_NOM = 800;
    localparam int V_TOTAL_NOM = 525;
    localparam int HS_PULSE    = 96;
    localparam int VS_PULSE    = 2;

endpackage

// File: rtl/edge_sampler.sv
// Input register stage for the VGA timing signals: pixel strobe and sync fall detection.
`timescale 1ns/1ps
module edge_sampler (
    input  logic clk,
    input  logic rst,
    input  logic pixel_clk,
    input  logic hs,
    input  logic vs,
    input  logic blank,
    output logic strobe,
    output logic hs_fall,
    output logic vs_fall,
    output logic blank_a
);

    logic pclk_a_q, pclk_a_d;
    logic hs_a_q, hs_a_d;
    logic vs_a_q, vs_a_d;
    logic blank_a_q, blank_a_d;
    logic pclk_prev_q, pclk_prev_d;
    logic hs_s_q, hs_s_d;
    logic vs_s_q, vs_s_d;

    assign strobe  = pclk_a_q & ~pclk_prev_q;
    // Sync levels are compared against the level seen at the previous strobe, not the previous Clk.
    assign hs_fall = strobe & hs_s_q & ~hs_a_q;
    assign vs_fall = strobe & vs_s_q & ~vs_a_q;
    assign blank_a = blank_a_q;

    always_comb begin
        pclk_a_d    = pixel_clk;
        hs_a_d      = hs;
        vs_a_d      = vs;
        blank_a_d   = blank;
        pclk_prev_d = pclk_a_q;
        hs_s_d      = hs_s_q;
        vs_s_d      = vs_s_q;
        if (strobe) begin
            hs_s_d = hs_a_q;
            vs_s_d = vs_a_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_a_q    <= 1'b0;
            hs_a_q      <= 1'b0;
            vs_a_q      <= 1'b0;
            blank_a_q   <= 1'b0;
            pclk_prev_q <= 1'b0;
            hs_s_q      <= 1'b0;
            vs_s_q      <= 1'b0;
        end else begin
            pclk_a_q    <= pclk_a_d;
            hs_a_q      <= hs_a_d;
            vs_a_q      <= vs_a_d;
            blank_a_q   <= blank_a_d;
            pclk_prev_q <= pclk_prev_d;
            hs_s_q      <= hs_s_d;
            vs_s_q      <= vs_s_d;
        end
    end

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from VGA hs/vs/blank, measures line/frame lengths and tracks lock.
`timescale 1ns/1ps
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int H_TOTAL     = H_TOTAL_NOM,
    parameter int V_TOTAL     = V_TOTAL_NOM,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pixel_clk,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank,
    input  logic        clr_err,
    output logic [9:0]  RxX,
    output logic [9:0]  RxY,
    output logic        rx_valid,
    output logic        frame_done,
    output logic [10:0] line_len,
    output logic [10:0] frame_lines,
    output logic        locked,
    output logic        err_h,
    output logic        err_v
);

    function automatic logic [10:0] inc_sat11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] inc_sat10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    logic strobe, hs_fall, vs_fall, blank_a;

    edge_sampler u_edge_sampler (
        .clk      (Clk),
        .rst      (Reset),
        .pixel_clk(pixel_clk),
        .hs       (hs),
        .vs       (vs),
        .blank    (blank),
        .strobe   (strobe),
        .hs_fall  (hs_fall),
        .vs_fall  (vs_fall),
        .blank_a  (blank_a)
    );

    sync_state_t state_q, state_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic [10:0] vlines_q, vlines_d;
    logic [10:0] line_len_q, line_len_d;
    logic [10:0] frame_lines_q, frame_lines_d;
    logic [9:0]  xact_q, xact_d;
    logic [9:0]  yact_q, yact_d;
    logic [9:0]  rxx_q, rxx_d;
    logic [7:0]  good_q, good_d;
    logic        line_act_q, line_act_d;
    logic        frame_bad_q, frame_bad_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        locked_q, locked_d;
    logic        err_h_q, err_h_d;
    logic        err_v_q, err_v_d;

    logic        checking;
    logic        line_err;
    logic        frame_err;
    logic        bad_frame;
    logic [10:0] hlen_now;
    logic [10:0] vlines_inc;

    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        vlines_d      = vlines_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        xact_d        = xact_q;
        yact_d        = yact_q;
        rxx_d         = rxx_q;
        good_d        = good_q;
        line_act_d    = line_act_q;
        frame_bad_d   = frame_bad_q;
        rx_valid_d    = 1'b0;
        frame_done_d  = 1'b0;
        checking      = (state_q != SEARCH);
        line_err      = 1'b0;
        frame_err     = 1'b0;
        bad_frame     = frame_bad_q;
        hlen_now      = inc_sat11(hcnt_q);
        vlines_inc    = vlines_q;

        if (strobe) begin
            hcnt_d = hlen_now;
            if (blank_a) begin
                rxx_d      = xact_q;
                xact_d     = inc_sat10(xact_q);
                rx_valid_d = 1'b1;
                line_act_d = 1'b1;
            end
            // The line closes before the frame so a coincident hs/vs fall counts in the old frame.
            if (hs_fall) begin
                line_len_d = hlen_now;
                hcnt_d     = 11'd0;
                xact_d     = 10'd0;
                line_act_d = 1'b0;
                vlines_inc = inc_sat11(vlines_q);
                vlines_d   = vlines_inc;
                if (line_act_q || blank_a) begin
                    yact_d = inc_sat10(yact_q);
                end
                line_err = checking && (hlen_now != 11'(H_TOTAL));
            end
            if (line_err) begin
                frame_bad_d = 1'b1;
            end
            if (vs_fall) begin
                frame_done_d  = 1'b1;
                frame_lines_d = vlines_inc;
                vlines_d      = 11'd0;
                yact_d        = 10'd0;
                frame_err     = checking && (vlines_inc != 11'(V_TOTAL));
                bad_frame     = frame_bad_q | line_err | frame_err;
                frame_bad_d   = 1'b0;
                case (state_q)
                    SEARCH: begin
                        state_d = ACQUIRE;
                        good_d  = 8'd0;
                    end
                    ACQUIRE: begin
                        if (bad_frame) begin
                            good_d = 8'd0;
                        end else begin
                            if (good_q != 8'hFF) good_d = good_q + 8'd1;
                            if (good_d >= 8'(LOCK_FRAMES)) state_d = LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (bad_frame) begin
                            state_d = SEARCH;
                            good_d  = 8'd0;
                        end
                    end
                    default: state_d = SEARCH;
                endcase
            end
        end

        err_h_d = err_h_q;
        err_v_d = err_v_q;
        if (clr_err) begin
            err_h_d = 1'b0;
            err_v_d = 1'b0;
        end
        if (line_err)  err_h_d = 1'b1;
        if (frame_err) err_v_d = 1'b1;
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= SEARCH;
            hcnt_q        <= 11'd0;
            vlines_q      <= 11'd0;
            line_len_q    <= 11'd0;
            frame_lines_q <= 11'd0;
            xact_q        <= 10'd0;
            yact_q        <= 10'd0;
            rxx_q         <= 10'd0;
            good_q        <= 8'd0;
            line_act_q    <= 1'b0;
            frame_bad_q   <= 1'b0;
            rx_valid_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            locked_q      <= 1'b0;
            err_h_q       <= 1'b0;
            err_v_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            vlines_q      <= vlines_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            xact_q        <= xact_d;
            yact_q        <= yact_d;
            rxx_q         <= rxx_d;
            good_q        <= good_d;
            line_act_q    <= line_act_d;
            frame_bad_q   <= frame_bad_d;
            rx_valid_q    <= rx_valid_d;
            frame_done_q  <= frame_done_d;
            locked_q      <= locked_d;
            err_h_q       <= err_h_d;
            err_v_q       <= err_v_d;
        end
    end

    assign RxX         = rxx_q;
    assign RxY         = yact_q;
    assign rx_valid    = rx_valid_q;
    assign frame_done  = frame_done_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign locked      = locked_q;
    assign err_h       = err_h_q;
    assign err_v       = err_v_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled 16x8 timing (24 pixels x 14 lines).
`timescale 1ns/1ps
module tb_vga_sync_decoder;
    import vga_pkg::*;

    localparam int HT = 24;
    localparam int VT = 14;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        pixel_clk = 1'b0;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic        blank = 1'b0;
    logic        clr_err = 1'b0;
    logic [9:0]  RxX, RxY;
    logic        rx_valid, frame_done;
    logic [10:0] line_len, frame_lines;
    logic        locked, err_h, err_v;

    int total = 0;
    int bad = 0;
    int rx_cnt = 0;
    int fd_cnt = 0;
    logic       armed = 1'b0;
    logic [9:0] first_x = '0, first_y = '0, last_x = '0, last_y = '0;
    int  vs_start_h = 0;
    logic clr_at_vs = 1'b0;

    vga_sync_decoder #(.H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(2)) dut (
        .Clk(Clk), .Reset(Reset), .pixel_clk(pixel_clk), .hs(hs), .vs(vs),
        .blank(blank), .clr_err(clr_err), .RxX(RxX), .RxY(RxY),
        .rx_valid(rx_valid), .frame_done(frame_done), .line_len(line_len),
        .frame_lines(frame_lines), .locked(locked), .err_h(err_h), .err_v(err_v)
    );

    always #10 Clk = ~Clk;

    always @(negedge Clk) begin
        if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            armed  = 1'b1;
        end
        if (rx_valid) begin
            rx_cnt = rx_cnt + 1;
            if (armed) begin
                first_x = RxX;
                first_y = RxY;
                armed   = 1'b0;
            end
            last_x = RxX;
            last_y = RxY;
        end
    end

    // Active 0..15 x 0..7, hs low at h 18..19, vs low from line 10 (h >= vs_start_h) through line 11.
    task automatic drive_span(input int v, input int h0, input int h1);
        for (int h = h0; h < h1; h++) begin
            @(posedge Clk); #1;
            clr_err   = 1'b0;
            pixel_clk = 1'b1;
            hs        = !(h >= 18 && h < 20);
            vs        = !((v == 10 && h >= vs_start_h) || v == 11);
            blank     = (h < 16) && (v < 8);
            @(posedge Clk); #1;
            pixel_clk = 1'b0;
            if (clr_at_vs && v == 10 && h == vs_start_h) begin
                clr_err   = 1'b1;
                clr_at_vs = 1'b0;
            end
        end
    endtask

    task automatic drive_frame(input int nlines);
        for (int v = 0; v < nlines; v++) drive_span(v, 0, HT);
    endtask

    task automatic pulse_clr();
        @(posedge Clk); #1 clr_err = 1'b1;
        @(posedge Clk); #1 clr_err = 1'b0;
    endtask

    task automatic test_reset();
        drive_span(0, 0, 5);
        total++;
        if ({RxX, RxY, line_len, frame_lines} !== 42'd0) begin
            bad++; $display("FAIL reset_counts: got %h want 0", {RxX, RxY, line_len, frame_lines});
        end
        total++;
        if ({rx_valid, frame_done, locked, err_h, err_v} !== 5'd0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000", {rx_valid, frame_done, locked, err_h, err_v});
        end
        Reset = 1'b0;
        drive_span(0, 5, HT);
        for (int v = 1; v < VT; v++) drive_span(v, 0, HT);
    endtask

    task automatic test_lock_acquire();
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL lock_after_f1: got %b want 0", locked); end
        drive_frame(VT);
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL lock_after_f2: got %b want 0", locked); end
        drive_frame(VT);
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL lock_after_f3: got %b want 1", locked); end
        total++;
        if ({err_h, err_v} !== 2'b00) begin bad++; $display("FAIL lock_errs: got %b want 00", {err_h, err_v}); end
        total++;
        if (line_len !== 11'd24) begin bad++; $display("FAIL lock_line_len: got %0d want 24", line_len); end
        total++;
        if (frame_lines !== 11'd14) begin bad++; $display("FAIL lock_frame_lines: got %0d want 14", frame_lines); end
    endtask

    task automatic test_active_stream();
        for (int f = 0; f < 2; f++) begin
            int rx0, fd0;
            rx0 = rx_cnt;
            fd0 = fd_cnt;
            drive_frame(VT);
            total++;
            if (rx_cnt - rx0 != 128) begin bad++; $display("FAIL rx_pulses: got %0d want 128", rx_cnt - rx0); end
            total++;
            if (fd_cnt - fd0 != 1) begin bad++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt - fd0); end
            total++;
            if ({first_x, first_y} !== {10'd0, 10'd0}) begin
                bad++; $display("FAIL first_pixel: got %0d,%0d want 0,0", first_x, first_y);
            end
            total++;
            if ({last_x, last_y} !== {10'd15, 10'd7}) begin
                bad++; $display("FAIL last_pixel: got %0d,%0d want 15,7", last_x, last_y);
            end
        end
    endtask

    task automatic test_line_stretch();
        drive_span(0, 0, HT);
        drive_span(1, 0, HT);
        drive_span(2, 0, HT);
        drive_span(3, 0, HT + 1);
        drive_span(4, 0, HT);
        total++;
        if (err_h !== 1'b1) begin bad++; $display("FAIL stretch_err_h: got %b want 1", err_h); end
        total++;
        if (line_len !== 11'd25) begin bad++; $display("FAIL stretch_line_len: got %0d want 25", line_len); end
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL stretch_lock_held: got %b want 1", locked); end
        for (int v = 5; v < VT; v++) drive_span(v, 0, HT);
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL stretch_lock_lost: got %b want 0", locked); end
        total++;
        if (dut.state_q !== SEARCH) begin bad++; $display("FAIL stretch_state: got %0d want %0d", dut.state_q, SEARCH); end
        drive_frame(VT);
        drive_frame(VT);
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL relock_early: got %b want 0", locked); end
        drive_frame(VT);
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL relock: got %b want 1", locked); end
        total++;
        if (err_h !== 1'b1) begin bad++; $display("FAIL err_h_sticky: got %b want 1", err_h); end
        pulse_clr();
        total++;
        if (err_h !== 1'b0) begin bad++; $display("FAIL err_h_clear: got %b want 0", err_h); end
    endtask

    task automatic test_short_frame();
        drive_frame(VT - 1);
        drive_frame(VT);
        total++;
        if (err_v !== 1'b1) begin bad++; $display("FAIL short_err_v: got %b want 1", err_v); end
        total++;
        if (frame_lines !== 11'd13) begin bad++; $display("FAIL short_frame_lines: got %0d want 13", frame_lines); end
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL short_lock_lost: got %b want 0", locked); end
        drive_frame(VT);
        pulse_clr();
        total++;
        if (err_v !== 1'b0) begin bad++; $display("FAIL err_v_clear: got %b want 0", err_v); end
        drive_frame(VT - 1);
        clr_at_vs = 1'b1;
        drive_frame(VT);
        total++;
        if (err_v !== 1'b1) begin bad++; $display("FAIL err_v_beats_clr: got %b want 1", err_v); end
        total++;
        if (frame_lines !== 11'd13) begin bad++; $display("FAIL short2_frame_lines: got %0d want 13", frame_lines); end
    endtask

    task automatic test_coincident();
        vs_start_h = 18;
        drive_frame(VT);
        total++;
        if (frame_lines !== 11'd15) begin bad++; $display("FAIL coinc_transition: got %0d want 15", frame_lines); end
        drive_frame(VT);
        total++;
        if (frame_lines !== 11'd14) begin bad++; $display("FAIL coinc_frame_lines: got %0d want 14", frame_lines); end
        drive_frame(VT);
        total++;
        if ({first_x, first_y} !== {10'd0, 10'd0}) begin
            bad++; $display("FAIL coinc_first_pixel: got %0d,%0d want 0,0", first_x, first_y);
        end
        total++;
        if (last_y !== 10'd7) begin bad++; $display("FAIL coinc_last_row: got %0d want 7", last_y); end
        vs_start_h = 0;
    endtask

    task automatic test_mid_reset_stall();
        int rx0;
        drive_span(0, 0, HT);
        drive_span(1, 0, HT);
        drive_span(2, 0, 5);
        Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0;
        total++;
        if ({RxX, RxY, line_len, frame_lines} !== 42'd0) begin
            bad++; $display("FAIL midreset_counts: got %h want 0", {RxX, RxY, line_len, frame_lines});
        end
        total++;
        if ({rx_valid, frame_done, locked, err_h, err_v} !== 5'd0) begin
            bad++; $display("FAIL midreset_flags: got %b want 00000", {rx_valid, frame_done, locked, err_h, err_v});
        end
        total++;
        if (dut.state_q !== SEARCH) begin bad++; $display("FAIL midreset_state: got %0d want %0d", dut.state_q, SEARCH); end
        rx0 = rx_cnt;
        repeat (1000) @(posedge Clk);
        #1;
        total++;
        if (rx_cnt != rx0) begin bad++; $display("FAIL stall_rx_valid: got %0d pulses want 0", rx_cnt - rx0); end
        total++;
        if ({RxX, line_len, locked} !== 22'd0) begin
            bad++; $display("FAIL stall_hold: got %h want 0", {RxX, line_len, locked});
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_active_stream();
        test_line_stretch();
        test_short_frame();
        test_coincident();
        test_mid_reset_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
